instr_fetch_unit: RTL and testbench

//   IF stage of the 5-stage RV32I core: owns the PC and issues word fetches to the synchronous-read

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_fetch_unit.sv | 91 +++++++++
 tb/tb_instr_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: widths, the canonical NOP, major opcodes
// and the fetch-buffer entry that pairs an instruction with its PC.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; push and pop may
// coincide on a full FIFO, and a pop on an empty FIFO is ignored.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only slots behind a valid count are ever observed.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues word fetches to synchronous IMEM under a
// credit limit, buffers tagged responses and handles EX redirects via an epoch bit.
module instr_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_en,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_rdata,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [XLEN-1:0]               out_pc
);

  import riscv_pkg::*;

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_valid;
  logic            inflight_epoch;
  logic            epoch;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_sum;
  logic            pop;
  logic            push;
  logic            issue;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  // A stale in-flight fetch still holds a credit until its response lands.
  assign pop        = out_valid && out_ready;
  assign credit_sum = {1'b0, count} + (CW+1)'(inflight_valid) - (CW+1)'(pop);
  assign issue      = rst && (credit_sum < (CW+1)'(FIFO_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = pc[AW+1:2];

  assign push      = inflight_valid && (inflight_epoch == epoch) && !redirect_valid;
  assign push_data = '{pc: inflight_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc             <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc    <= '0;
      epoch          <= 1'b0;
    end else begin
      inflight_valid <= issue;
      inflight_pc    <= pc;
      inflight_epoch <= epoch;
      if (redirect_valid) begin
        pc    <= {redirect_pc[XLEN-1:2], 2'b00};
        epoch <= ~epoch;
      end else if (issue) begin
        pc <= pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? head.instr : NOP_INSTR;
  assign out_pc    = out_valid ? head.pc : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a per-cycle vector table for reset, latency, stall
// and redirect timing, plus a scoreboard checking every accepted {pc, instr}.
module tb_instr_fetch_unit;

  localparam int          IMEM_DEPTH = 64;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic [31:0] imem [IMEM_DEPTH];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_en;
    logic [5:0]  exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  exp_t exp_q[$];
  exp_t sb_e;
  vec_t vecs [20];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem[imem_addr];
  end

  function automatic logic [31:0] gen_instr(input int k);
    logic [4:0] rd;
    logic [4:0] rs;
    rd = 5'((k % 31) + 1);
    rs = 5'(k % 32);
    case (k % 3)
      0:       return {12'(k), 5'd0, 3'b000, rd, 7'b0010011};
      1:       return {7'b0000000, rs, rd, 3'b000, rd, 7'b0110011};
      default: return {7'b0100000, rs, rd, 3'b000, rd, 7'b0110011};
    endcase
  endfunction

  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    return gen_instr(int'(pc[7:2]));
  endfunction

  function automatic vec_t mk(input logic r, input logic ready, input logic rv,
                              input logic [31:0] rpc, input logic en,
                              input logic [5:0] addr, input logic v,
                              input logic [31:0] pc);
    vec_t t;
    t.rst = r; t.ready = ready; t.rv = rv; t.rpc = rpc;
    t.exp_en = en; t.exp_addr = addr; t.exp_valid = v; t.exp_pc = pc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rebase(input logic [31:0] start);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = instr_at(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ready, input logic rv,
                               input logic [31:0] rpc);
    rst            = r;
    out_ready      = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [31:0] exp_instr;
    exp_instr = v.exp_valid ? instr_at(v.exp_pc) : NOP;
    check($sformatf("row%0d_imem_en", idx),   32'(imem_en),   32'(v.exp_en));
    check($sformatf("row%0d_imem_addr", idx), 32'(imem_addr), 32'(v.exp_addr));
    check($sformatf("row%0d_out_valid", idx), 32'(out_valid), 32'(v.exp_valid));
    check($sformatf("row%0d_out_pc", idx),    out_pc,         v.exp_pc);
    check($sformatf("row%0d_out_instr", idx), out_instr,      exp_instr);
  endtask

  // Advance one clock; a reset or redirect at that edge restarts the expected stream.
  task automatic tick();
    logic        was_rst;
    logic        was_rv;
    logic [31:0] tgt;
    was_rst = (rst == 1'b0);
    was_rv  = redirect_valid;
    tgt     = {redirect_pc[31:2], 2'b00};
    @(posedge clk);
    #1;
    if (was_rst)     rebase(32'h0);
    else if (was_rv) rebase(tgt);
  endtask

  task automatic run_cycles(input int n, input logic ready);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, ready, 1'b0, 32'h0);
      @(negedge clk);
      tick();
    end
  endtask

  // Scoreboard: every accepted handshake must match the next expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL sb_underflow: got pc %h, expected nothing", out_pc);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_pc", out_pc, sb_e.pc);
        check("sb_instr", out_instr, sb_e.instr);
        n_pop++;
      end
    end
  end

  initial begin
    int pops_before;

    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = gen_instr(i);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    //            rst   rdy   rv    rpc    en    addr   valid pc
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'd0,  1'b0, 32'h00);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'd0,  1'b0, 32'h00);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'd0,  1'b0, 32'h00);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd0,  1'b0, 32'h00);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd1,  1'b0, 32'h00);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd2,  1'b1, 32'h00);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd3,  1'b1, 32'h04);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd4,  1'b1, 32'h08);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd4,  1'b1, 32'h08);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd4,  1'b1, 32'h08);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd4,  1'b1, 32'h08);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd4,  1'b1, 32'h08);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd4,  1'b1, 32'h08);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd5,  1'b1, 32'h0C);
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd6,  1'b1, 32'h10);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd7,  1'b1, 32'h14);
    vecs[16] = mk(1'b1, 1'b0, 1'b1, 32'h5C, 1'b0, 6'd7, 1'b1, 32'h14);
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd23, 1'b0, 32'h00);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd24, 1'b0, 32'h00);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 6'd25, 1'b1, 32'h5C);

    tick();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ready, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
      checkOutput(vecs[i], i);
      tick();
    end

    // Redirect to a misaligned target while decode accepts the head.
    run_cycles(3, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h5E);
    @(negedge clk);
    check("redir_pop_valid", 32'(out_valid), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("redir_next_valid", 32'(out_valid), 32'd0);
    check("redir_next_en", 32'(imem_en), 32'd1);
    check("redir_next_addr", 32'(imem_addr), 32'd23);
    tick();
    run_cycles(4, 1'b1);

    // Back-to-back redirects: the second target wins.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
    @(negedge clk);
    check("b2b_valid", 32'(out_valid), 32'd0);
    check("b2b_addr", 32'(imem_addr), 32'd16);
    tick();
    run_cycles(6, 1'b1);

    // Word-index wrap at the top of IMEM while pc keeps counting.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFC);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("wrap_addr_top", 32'(imem_addr), 32'd63);
    tick();
    @(negedge clk);
    check("wrap_addr_zero", 32'(imem_addr), 32'd0);
    check("wrap_en", 32'(imem_en), 32'd1);
    tick();
    run_cycles(5, 1'b1);

    // Reset mid-stream with a stalled, buffered FIFO and a fetch in flight.
    run_cycles(1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_instr", out_instr, NOP);
    check("mid_rst_en", 32'(imem_en), 32'd1);
    check("mid_rst_addr", 32'(imem_addr), 32'd0);
    pops_before = n_pop;
    tick();
    run_cycles(11, 1'b1);
    check("stream_pops", 32'(n_pop - pops_before), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
